// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer
//
// Write-back buffer and read-forwarding stage between the data cache and the
// data-side line ports of the AXI bridge. Evicted dirty lines are queued in a
// small circular FIFO and drained one line at a time to the bridge write port.
// Line fills from the cache go to the bridge read port. A fill whose line
// address matches a queued eviction is served from the buffer instead, so a
// fill can never return memory data that is older than a pending write-back.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   wb_valid/wb_ready         eviction handshake (wb_addr, wb_data)
//   c_rvalid/c_raddr          fill request from the cache, held until c_rready
//   c_rready/c_rdata          one-cycle fill completion with line data
//   d_wvalid/d_waddr/d_wdata  head entry presented to the bridge write port
//   d_wready                  bridge pulse: last write beat accepted
//   d_wlen/d_wstrb            constant burst length / byte strobes
//   d_rvalid/d_raddr          miss request to the bridge read port
//   d_rready/d_rdata          bridge pulse with the fill line data
//   d_rlen                    constant burst length

module dcache_wb_buffer #(
    parameter int DEPTH      = 2,
    parameter int LINE_BEATS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [31:0]  wb_addr,
    input  logic [511:0] wb_data,
    input  logic         c_rvalid,
    input  logic [31:0]  c_raddr,
    output logic         c_rready,
    output logic [511:0] c_rdata,
    output logic [31:0]  d_waddr,
    output logic [511:0] d_wdata,
    output logic         d_wvalid,
    input  logic         d_wready,
    output logic [7:0]   d_wlen,
    output logic [3:0]   d_wstrb,
    output logic [31:0]  d_raddr,
    output logic         d_rvalid,
    input  logic         d_rready,
    input  logic [511:0] d_rdata,
    output logic [7:0]   d_rlen
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_MISS
    } rstate_t;

    // Entry storage
    logic [DEPTH-1:0] ent_valid;
    logic [25:0]      ent_addr [DEPTH];
    logic [511:0]     ent_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    // Fill path
    rstate_t          rstate;
    rstate_t          rstate_nx;
    logic             fwd_phase;
    logic             fwd_phase_nx;
    logic [511:0]     fwd_buf;
    logic [25:0]      miss_addr;
    logic             load_fwd;
    logic             load_miss;

    // Hit search
    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic [PTR_W-1:0] scan_idx;

    logic             enq;
    logic             deq;

    // Pointer arithmetic modulo DEPTH; k is always below DEPTH so a single
    // conditional subtract covers the wrap for non-power-of-two depths too.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        logic [PTR_W+1:0] s;
        s = {2'b00, p} + (PTR_W+2)'(k);
        if (s >= (PTR_W+2)'(DEPTH))
            s = s - (PTR_W+2)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    assign d_wlen  = 8'(LINE_BEATS - 1);
    assign d_rlen  = 8'(LINE_BEATS - 1);
    assign d_wstrb = 4'hF;

    // A line that is currently being fetched from memory may not be queued
    // again until the fill returns, otherwise the fill would miss it.
    assign wb_ready = (count < CNT_W'(DEPTH))
                    & ~((rstate == R_MISS) && (wb_addr[31:6] == miss_addr));
    assign enq      = wb_valid & wb_ready;

    assign d_wvalid = (count != '0);
    assign deq      = d_wvalid & d_wready;
    // Entry contents are not reset, so the write port is forced to zero while
    // empty rather than exposing stale or uninitialised storage.
    assign d_waddr  = d_wvalid ? {ent_addr[head], 6'b0} : 32'h0;
    assign d_wdata  = d_wvalid ? ent_data[head] : 512'h0;

    // Queue bookkeeping
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (deq) begin
                ent_valid[head] <= 1'b0;
                head            <= ptr_add(head, 1);
            end
            if (enq) begin
                ent_valid[tail] <= 1'b1;
                tail            <= ptr_add(tail, 1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: line storage and the forward buffer carry no reset; only the valid
    // bits and pointers define whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail] <= wb_addr[31:6];
            ent_data[tail] <= wb_data;
        end
        if (load_fwd)
            fwd_buf <= ent_data[hit_idx];
    end

    // Scan from oldest (head) to youngest so the last match, the youngest
    // copy of the line, is the one that gets forwarded.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = ptr_add(head, i);
            if (ent_valid[scan_idx] && (ent_addr[scan_idx] == c_raddr[31:6])) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    // Fill FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate    <= R_IDLE;
            fwd_phase <= 1'b0;
            miss_addr <= '0;
        end else begin
            rstate    <= rstate_nx;
            fwd_phase <= fwd_phase_nx;
            if (load_miss)
                miss_addr <= c_raddr[31:6];
        end
    end

    // Fill FSM next state and outputs. A forward spends two cycles in R_FWD:
    // the first lets fwd_buf settle after the capture, the second returns it.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a latch behind.
    always_comb begin
        rstate_nx    = rstate;
        fwd_phase_nx = 1'b0;
        load_fwd     = 1'b0;
        load_miss    = 1'b0;
        c_rready     = 1'b0;
        c_rdata      = '0;
        d_rvalid     = 1'b0;
        d_raddr      = '0;
        case (rstate)
            R_IDLE: begin
                if (c_rvalid) begin
                    if (hit) begin
                        load_fwd  = 1'b1;
                        rstate_nx = R_FWD;
                    end else begin
                        load_miss = 1'b1;
                        rstate_nx = R_MISS;
                    end
                end
            end
            R_FWD: begin
                if (!fwd_phase) begin
                    fwd_phase_nx = 1'b1;
                end else begin
                    c_rready  = 1'b1;
                    c_rdata   = fwd_buf;
                    rstate_nx = R_IDLE;
                end
            end
            R_MISS: begin
                d_rvalid = 1'b1;
                d_raddr  = {miss_addr, 6'b0};
                if (d_rready) begin
                    c_rready  = 1'b1;
                    c_rdata   = d_rdata;
                    rstate_nx = R_IDLE;
                end
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer
//
// Directed bench for dcache_wb_buffer (DEPTH=2, LINE_BEATS=16). Inputs change
// 1 ns after each rising edge; outputs are compared a further 1 ns later.

module tb_dcache_wb_buffer;

    logic         clk;
    logic         rst;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;
    logic         c_rvalid;
    logic [31:0]  c_raddr;
    logic         c_rready;
    logic [511:0] c_rdata;
    logic [31:0]  d_waddr;
    logic [511:0] d_wdata;
    logic         d_wvalid;
    logic         d_wready;
    logic [7:0]   d_wlen;
    logic [3:0]   d_wstrb;
    logic [31:0]  d_raddr;
    logic         d_rvalid;
    logic         d_rready;
    logic [511:0] d_rdata;
    logic [7:0]   d_rlen;

    int checks = 0;
    int errors = 0;

    dcache_wb_buffer #(.DEPTH(2), .LINE_BEATS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .c_rvalid (c_rvalid),
        .c_raddr  (c_raddr),
        .c_rready (c_rready),
        .c_rdata  (c_rdata),
        .d_waddr  (d_waddr),
        .d_wdata  (d_wdata),
        .d_wvalid (d_wvalid),
        .d_wready (d_wready),
        .d_wlen   (d_wlen),
        .d_wstrb  (d_wstrb),
        .d_raddr  (d_raddr),
        .d_rvalid (d_rvalid),
        .d_rready (d_rready),
        .d_rdata  (d_rdata),
        .d_rlen   (d_rlen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Line with beat i = base + i
    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic enqueue(input logic [31:0] a, input logic [511:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic drain_one();
        d_wready = 1'b1;
        tick();
        d_wready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] d0, d1, d2, dr;
        logic         unstable;
        logic         rv_seen;

        d0 = make_line(32'h0000_0000);
        d1 = make_line(32'hD100_0000);
        d2 = make_line(32'hD200_0000);
        dr = make_line(32'hAA00_0000);

        rst      = 1'b1;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        c_rvalid = 1'b0;
        c_raddr  = '0;
        d_wready = 1'b0;
        d_rready = 1'b0;
        d_rdata  = '0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_wb_ready", wb_ready, 1);
        check("rst_d_wvalid", d_wvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_c_rready", c_rready, 0);
        check("rst_d_wlen",   d_wlen,   15);
        check("rst_d_rlen",   d_rlen,   15);
        check("rst_d_wstrb",  d_wstrb,  4'hF);

        // Single write-back held for 20 cycles
        wb_valid = 1'b1;
        wb_addr  = 32'h1000_0040;
        wb_data  = d0;
        settle();
        check("single_wb_ready", wb_ready, 1);
        check("single_pre_wvalid", d_wvalid, 0);
        tick();
        wb_valid = 1'b0;
        settle();
        check("single_wvalid", d_wvalid, 1);
        check("single_waddr",  d_waddr,  32'h1000_0040);
        check("single_wdata",  d_wdata,  d0);
        unstable = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (d_wvalid !== 1'b1 || d_waddr !== 32'h1000_0040 || d_wdata !== d0)
                unstable = 1'b1;
        end
        check("single_stable", unstable, 0);
        drain_one();
        settle();
        check("single_after_deq", d_wvalid, 0);

        // Full: two entries queued, third offered with a low address nibble
        enqueue(32'h0000_0100, make_line(32'h0000_0100));
        enqueue(32'h0000_0200, make_line(32'h0000_0200));
        wb_valid = 1'b1;
        wb_addr  = 32'h0000_0305;
        wb_data  = make_line(32'h0000_0300);
        settle();
        check("full_wb_ready", wb_ready, 0);
        check("full_head", d_waddr, 32'h0000_0100);
        d_wready = 1'b1;
        settle();
        check("full_ready_with_deq", wb_ready, 0);
        tick();
        d_wready = 1'b0;
        settle();
        check("full_ready_after_deq", wb_ready, 1);
        check("full_head2", d_waddr, 32'h0000_0200);
        tick();
        wb_valid = 1'b0;
        settle();
        check("full_order_200", d_waddr, 32'h0000_0200);
        drain_one();
        settle();
        check("full_order_300", d_waddr, 32'h0000_0300);
        check("full_data_300", d_wdata, make_line(32'h0000_0300));
        drain_one();
        settle();
        check("full_empty", d_wvalid, 0);

        // Forward hit: youngest of two same-line entries is returned
        enqueue(32'h2000_0080, d1);
        enqueue(32'h2000_0080, d2);
        c_rvalid = 1'b1;
        c_raddr  = 32'h2000_0084;
        rv_seen  = 1'b0;
        tick();
        if (d_rvalid !== 1'b0) rv_seen = 1'b1;
        check("hit_cyc1_rready", c_rready, 0);
        tick();
        if (d_rvalid !== 1'b0) rv_seen = 1'b1;
        check("hit_cyc2_rready", c_rready, 1);
        check("hit_rdata", c_rdata, d2);
        c_rvalid = 1'b0;
        tick();
        if (d_rvalid !== 1'b0) rv_seen = 1'b1;
        check("hit_pulse_end", c_rready, 0);
        check("hit_no_d_rvalid", rv_seen, 0);
        drain_one();
        drain_one();
        settle();
        check("hit_drained", d_wvalid, 0);

        // Miss and same-line write-back hazard
        c_rvalid = 1'b1;
        c_raddr  = 32'h3000_0000;
        settle();
        check("miss_pre_rvalid", d_rvalid, 0);
        tick();
        check("miss_rvalid", d_rvalid, 1);
        check("miss_raddr",  d_raddr,  32'h3000_0000);
        check("miss_no_rready", c_rready, 0);
        wb_valid = 1'b1;
        wb_addr  = 32'h3000_0000;
        wb_data  = d1;
        settle();
        check("hazard_block", wb_ready, 0);
        wb_addr = 32'h3000_0040;
        settle();
        check("hazard_other_line", wb_ready, 1);
        tick();
        wb_valid = 1'b0;
        settle();
        check("hazard_enq_wvalid", d_wvalid, 1);
        check("hazard_enq_waddr",  d_waddr,  32'h3000_0040);
        tick();
        tick();
        check("miss_wait_rready", c_rready, 0);
        check("miss_wait_rvalid", d_rvalid, 1);
        d_rready = 1'b1;
        d_rdata  = dr;
        settle();
        check("miss_rready", c_rready, 1);
        check("miss_rdata",  c_rdata,  dr);
        tick();
        d_rready = 1'b0;
        c_rvalid = 1'b0;
        settle();
        check("miss_done_rready", c_rready, 0);
        check("miss_done_rvalid", d_rvalid, 0);
        drain_one();

        // Reset in the middle of a miss with two lines queued
        enqueue(32'h4000_0000, d1);
        enqueue(32'h4000_0040, d2);
        c_rvalid = 1'b1;
        c_raddr  = 32'h5000_0000;
        tick();
        check("mid_pre_rvalid", d_rvalid, 1);
        check("mid_pre_wvalid", d_wvalid, 1);
        check("mid_pre_full",   wb_ready, 0);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        c_rvalid = 1'b0;
        settle();
        check("mid_wvalid",   d_wvalid, 0);
        check("mid_rvalid",   d_rvalid, 0);
        check("mid_wb_ready", wb_ready, 1);
        check("mid_c_rready", c_rready, 0);
        d_rready = 1'b1;
        d_rdata  = dr;
        settle();
        check("mid_ignore_d_rready", c_rready, 0);
        tick();
        d_rready = 1'b0;
        tick();
        check("mid_still_idle", c_rready, 0);
        check("mid_still_empty", d_wvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
